// File: rtl/reg_encoder_q.sv
// Queued 16-to-4 request encoder: accumulates multi-hot register requests and
// emits them one index per handshake with wrapping round-robin priority.
module reg_encoder_q #(
   parameter int unsigned NREG = 16,
   parameter int unsigned IDXW = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            FLUSH,
   input  logic [NREG-1:0] REQ_IN,
   output logic            OUT_VALID,
   output logic [IDXW-1:0] OUT_IDX,
   input  logic            OUT_READY,
   output logic [NREG-1:0] PEND_O,
   output logic            BUSY
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t          r_state;
   logic [NREG-1:0] r_pend;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] r_out_idx;
   logic            r_out_valid;

   logic            w_found;
   logic [IDXW-1:0] w_pick;
   logic [IDXW-1:0] w_next_ptr;
   logic            w_load;
   logic [NREG-1:0] w_mask;
   int unsigned     w_pos;

   // First pending bit at or after r_ptr, wrapping past NREG-1 back to 0.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_pos   = 0;
      for (int unsigned i = 0; i < NREG; i++) begin
         w_pos = (32'(r_ptr) + i) % NREG;
         if (!w_found && r_pend[w_pos[IDXW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_pos[IDXW-1:0];
         end
      end
   end

   always_comb begin
      w_next_ptr = (w_pick == IDXW'(NREG - 1)) ? '0 : w_pick + IDXW'(1);
      w_load     = w_found && ((r_state == IDLE) || OUT_READY);
      w_mask     = w_load ? (NREG'(1) << w_pick) : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= IDLE;
         r_pend      <= '0;
         r_ptr       <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
      end else if (FLUSH) begin
         r_state     <= IDLE;
         r_pend      <= '0;
         r_ptr       <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // New requests are OR'ed after the clear so a same-edge re-request survives.
         r_pend <= (r_pend & ~w_mask) | REQ_IN;
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_out_idx   <= w_pick;
                  r_ptr       <= w_next_ptr;
                  r_out_valid <= 1'b1;
                  r_state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (OUT_READY) begin
                  if (w_load) begin
                     r_out_idx <= w_pick;
                     r_ptr     <= w_next_ptr;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_state     <= IDLE;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign OUT_VALID = r_out_valid;
   assign OUT_IDX   = r_out_idx;
   assign PEND_O    = r_pend;
   assign BUSY      = r_out_valid | (|r_pend);

endmodule
